// File: rtl/disparity_search_if.sv
// Request/result handshake bundle for disparity_search_pipe: strip pair and window
// column in, winning disparity and its SAD out, each side with valid/ready.
interface disparity_search_if #(
  parameter int WIN       = 15,
  parameter int DATA_SIZE = 8,
  parameter int IMG_W     = 64,
  parameter int MAX_DISP  = 64
);
  localparam int SAD_BITS   = $clog2(WIN * WIN * ((1 << DATA_SIZE) - 1) + 1);
  localparam int DISP_BITS  = (MAX_DISP > 1) ? $clog2(MAX_DISP) : 1;
  localparam int COL_BITS   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int STRIP_BITS = DATA_SIZE * IMG_W * WIN;

  logic                  in_valid;
  logic                  in_ready;
  logic [STRIP_BITS-1:0] strip_L;
  logic [STRIP_BITS-1:0] strip_R;
  logic [COL_BITS-1:0]   col_index;

  logic                  out_valid;
  logic                  out_ready;
  logic [DISP_BITS-1:0]  out_disp;
  logic [SAD_BITS-1:0]   out_sad;
  logic [COL_BITS-1:0]   out_col;
  logic                  out_none;

  modport master (
    output in_valid, strip_L, strip_R, col_index, out_ready,
    input  in_ready, out_valid, out_disp, out_sad, out_col, out_none
  );

  modport slave (
    input  in_valid, strip_L, strip_R, col_index, out_ready,
    output in_ready, out_valid, out_disp, out_sad, out_col, out_none
  );
endinterface

// File: rtl/disparity_search_pipe.sv
// Block-matching disparity search: scores DISP_THREADS candidate disparities per cycle
// over a registered strip pair and reports the lowest-SAD legal one (ties -> lowest d).
module disparity_search_pipe #(
  parameter int WIN          = 15,
  parameter int DATA_SIZE    = 8,
  parameter int IMG_W        = 64,
  parameter int MAX_DISP     = 64,
  parameter int DISP_THREADS = 16
) (
  input logic               clk,
  input logic               rst_n,
  disparity_search_if.slave bus
);
  localparam int SAD_BITS   = $clog2(WIN * WIN * ((1 << DATA_SIZE) - 1) + 1);
  localparam int DISP_BITS  = (MAX_DISP > 1) ? $clog2(MAX_DISP) : 1;
  localparam int COL_BITS   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int STRIP_BITS = DATA_SIZE * IMG_W * WIN;
  localparam int G          = MAX_DISP / DISP_THREADS;
  localparam int GRP_BITS   = (G > 1) ? $clog2(G) : 1;

  typedef enum logic [1:0] {IDLE, COMPUTE, OUT} state_t;

  state_t state_q, state_d;

  logic [STRIP_BITS-1:0] strip_l_q;
  logic [STRIP_BITS-1:0] strip_r_q;
  logic [COL_BITS-1:0]   col_q;
  logic [GRP_BITS-1:0]   group_q;
  logic [SAD_BITS-1:0]   best_sad_q;
  logic [DISP_BITS-1:0]  best_disp_q;
  logic                  any_legal_q;

  logic [SAD_BITS-1:0]     cand_sad [DISP_THREADS];
  logic [DISP_THREADS-1:0] cand_legal;
  logic                    grp_found;
  logic [SAD_BITS-1:0]     grp_sad;
  logic [DISP_BITS-1:0]    grp_disp;
  logic                    new_best;
  logic [SAD_BITS-1:0]     best_sad_next;
  logic                    compute_done;
  logic                    accept;

  assign accept = bus.in_valid && (state_q == IDLE);

  // Illegal candidates read pixel 0 instead of their real window, so no index ever
  // leaves the strip; their SAD is ignored by the selector anyway.
  always_comb begin
    int d;
    int li;
    int ri;
    logic [DATA_SIZE-1:0] lp;
    logic [DATA_SIZE-1:0] rp;
    d  = 0;
    li = 0;
    ri = 0;
    lp = '0;
    rp = '0;
    for (int t = 0; t < DISP_THREADS; t++) begin
      d             = int'(group_q) * DISP_THREADS + t;
      cand_legal[t] = (int'(col_q) + d + WIN - 1) <= (IMG_W - 1);
      cand_sad[t]   = '0;
      for (int r = 0; r < WIN; r++) begin
        for (int c = 0; c < WIN; c++) begin
          li = cand_legal[t] ? int'(col_q) + c : 0;
          ri = cand_legal[t] ? int'(col_q) + c + d : 0;
          lp = strip_l_q[DATA_SIZE * (r * IMG_W + li) +: DATA_SIZE];
          rp = strip_r_q[DATA_SIZE * (r * IMG_W + ri) +: DATA_SIZE];
          cand_sad[t] = cand_sad[t] + SAD_BITS'((lp > rp) ? (lp - rp) : (rp - lp));
        end
      end
    end
  end

  always_comb begin
    grp_found = 1'b0;
    grp_sad   = '1;
    grp_disp  = '0;
    for (int t = 0; t < DISP_THREADS; t++) begin
      if (cand_legal[t] && (!grp_found || (cand_sad[t] < grp_sad))) begin
        grp_found = 1'b1;
        grp_sad   = cand_sad[t];
        grp_disp  = DISP_BITS'(int'(group_q) * DISP_THREADS + t);
      end
    end
  end

  // Strict compare keeps the earlier group on a tie; also decides when to stop early.
  always_comb begin
    int next_base;
    new_best      = grp_found && (grp_sad < best_sad_q);
    best_sad_next = new_best ? grp_sad : best_sad_q;
    next_base     = (int'(group_q) + 1) * DISP_THREADS;
    compute_done  = (int'(group_q) == G - 1) ||
                    (best_sad_next == '0) ||
                    ((int'(col_q) + next_base + WIN - 1) > (IMG_W - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = COMPUTE;
      COMPUTE: if (compute_done)  state_d = OUT;
      OUT:     if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result ports are gated by OUT so reset (or any other state) presents zeros.
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = 1'b0;
    bus.out_disp  = '0;
    bus.out_sad   = '0;
    bus.out_col   = '0;
    bus.out_none  = 1'b0;
    if (state_q == OUT) begin
      bus.out_valid = 1'b1;
      bus.out_disp  = best_disp_q;
      bus.out_sad   = best_sad_q;
      bus.out_col   = col_q;
      bus.out_none  = !any_legal_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strip_l_q   <= '0;
      strip_r_q   <= '0;
      col_q       <= '0;
      group_q     <= '0;
      best_sad_q  <= '1;
      best_disp_q <= '0;
      any_legal_q <= 1'b0;
    end else if (accept) begin
      strip_l_q   <= bus.strip_L;
      strip_r_q   <= bus.strip_R;
      col_q       <= bus.col_index;
      group_q     <= '0;
      best_sad_q  <= '1;
      best_disp_q <= '0;
      any_legal_q <= 1'b0;
    end else if (state_q == COMPUTE) begin
      group_q <= group_q + GRP_BITS'(1);
      if (new_best) begin
        best_sad_q  <= grp_sad;
        best_disp_q <= grp_disp;
      end
      if (grp_found) any_legal_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_disparity_search_pipe.sv
// Directed bench for disparity_search_pipe (WIN=3, IMG_W=16, MAX_DISP=8, 4 threads).
module tb_disparity_search_pipe;
  localparam int WIN          = 3;
  localparam int DATA_SIZE    = 8;
  localparam int IMG_W        = 16;
  localparam int MAX_DISP     = 8;
  localparam int DISP_THREADS = 4;
  localparam int SW           = DATA_SIZE * IMG_W * WIN;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_compared   = 0;
  int   n_mismatched = 0;
  int   lat;
  logic [SW-1:0] ramp;

  always #5 clk = ~clk;

  disparity_search_if #(.WIN(WIN), .DATA_SIZE(DATA_SIZE), .IMG_W(IMG_W), .MAX_DISP(MAX_DISP)) bus ();

  disparity_search_pipe #(
    .WIN(WIN), .DATA_SIZE(DATA_SIZE), .IMG_W(IMG_W),
    .MAX_DISP(MAX_DISP), .DISP_THREADS(DISP_THREADS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Distinct pixel values 1..48 so only an exact shift gives SAD 0
  function automatic logic [SW-1:0] ramp_strip();
    logic [SW-1:0] s;
    s = '0;
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < IMG_W; c++)
        s[DATA_SIZE*(r*IMG_W+c) +: DATA_SIZE] = 8'(16 * r + c + 1);
    return s;
  endfunction

  function automatic logic [SW-1:0] shift_strip(input logic [SW-1:0] src, input int sh);
    logic [SW-1:0] s;
    s = '0;
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < IMG_W; c++)
        s[DATA_SIZE*(r*IMG_W+c) +: DATA_SIZE] =
          (c >= sh) ? src[DATA_SIZE*(r*IMG_W+c-sh) +: DATA_SIZE] : 8'hAA;
    return s;
  endfunction

  function automatic logic [SW-1:0] fill_strip(input logic [7:0] v);
    logic [SW-1:0] s;
    for (int p = 0; p < IMG_W * WIN; p++) s[DATA_SIZE*p +: DATA_SIZE] = v;
    return s;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] col, input logic [SW-1:0] l, input logic [SW-1:0] r);
    @(negedge clk);
    bus.strip_L   = l;
    bus.strip_R   = r;
    bus.col_index = col;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.strip_L  = '1;
    bus.strip_R  = '0;
    check_output("accepted", 32'(bus.in_ready), 32'd0);
  endtask

  task automatic wait_result(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (!bus.out_valid && cycles < 20);
  endtask

  task automatic check_result(input string tag, input int exp_lat, input int cycles,
                              input int disp, input int sad, input int col, input int none);
    check_output({tag, ".latency"}, 32'(cycles), 32'(exp_lat));
    check_output({tag, ".valid"},   32'(bus.out_valid), 32'd1);
    check_output({tag, ".disp"},    32'(bus.out_disp), 32'(disp));
    check_output({tag, ".sad"},     32'(bus.out_sad), 32'(sad));
    check_output({tag, ".col"},     32'(bus.out_col), 32'(col));
    check_output({tag, ".none"},    32'(bus.out_none), 32'(none));
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, ".in_ready"},  32'(bus.in_ready), 32'd1);
    check_output({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
    check_output({tag, ".out_disp"},  32'(bus.out_disp), 32'd0);
    check_output({tag, ".out_sad"},   32'(bus.out_sad), 32'd0);
    check_output({tag, ".out_col"},   32'(bus.out_col), 32'd0);
    check_output({tag, ".out_none"},  32'(bus.out_none), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.strip_L   = '0;
    bus.strip_R   = '0;
    bus.col_index = '0;
    ramp          = ramp_strip();

    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    #2 rst_n = 1'b1;

    // Match at d=6 from col 2: group 0 has no zero, group 1 finds it -> two cycles
    apply_stimulus(4'd2, ramp, shift_strip(ramp, 6));
    wait_result(lat);
    check_result("match_d6", 2, lat, 6, 0, 2, 0);
    @(posedge clk); #1;
    check_output("match_d6.release", 32'(bus.in_ready), 32'd1);

    // Match at d=2 from col 0: best reaches 0 in group 0 -> early exit
    apply_stimulus(4'd0, ramp, shift_strip(ramp, 2));
    wait_result(lat);
    check_result("match_d2", 1, lat, 2, 0, 0, 0);
    @(posedge clk); #1;

    // All-zero strips: every SAD ties at 0, lowest d wins
    apply_stimulus(4'd0, fill_strip(8'h00), fill_strip(8'h00));
    wait_result(lat);
    check_result("all_zero", 1, lat, 0, 0, 0, 0);
    @(posedge clk); #1;

    // col 12: only d=0 (SAD 9*16=144) and d=1 (6*16=96) legal -> d=1 wins
    ramp = fill_strip(8'h00);
    for (int r = 0; r < WIN; r++) ramp[DATA_SIZE*(r*IMG_W+15) +: DATA_SIZE] = 8'h10;
    apply_stimulus(4'd12, fill_strip(8'h10), ramp);
    wait_result(lat);
    check_result("edge_c12", 1, lat, 1, 96, 12, 0);
    @(posedge clk); #1;

    // col 14: no candidate fits inside the strip
    apply_stimulus(4'd14, fill_strip(8'h10), ramp);
    wait_result(lat);
    check_result("none_c14", 1, lat, 0, 12'hFFF, 14, 1);
    @(posedge clk); #1;

    // Back-pressure: result held, new requests ignored while OUT
    bus.out_ready = 1'b0;
    apply_stimulus(4'd12, fill_strip(8'h10), ramp);
    wait_result(lat);
    check_result("hold", 1, lat, 1, 96, 12, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.col_index = 4'd3;
      @(posedge clk); #1;
      check_output("hold.valid",    32'(bus.out_valid), 32'd1);
      check_output("hold.disp",     32'(bus.out_disp), 32'd1);
      check_output("hold.sad",      32'(bus.out_sad), 32'd96);
      check_output("hold.col",      32'(bus.out_col), 32'd12);
      check_output("hold.in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check_output("hold.drop_valid", 32'(bus.out_valid), 32'd0);
    check_output("hold.in_ready",   32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    check_output("hold.stay_idle",  32'(bus.in_ready), 32'd1);

    // Reset asserted mid-COMPUTE, between clock edges
    ramp = ramp_strip();
    apply_stimulus(4'd2, ramp, shift_strip(ramp, 6));
    #2 rst_n = 1'b0;
    #1;
    check_idle("rst_compute");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_output("rst_compute.no_result", 32'(bus.out_valid), 32'd0);
    end
    apply_stimulus(4'd0, ramp, shift_strip(ramp, 2));
    wait_result(lat);
    check_result("after_rst", 1, lat, 2, 0, 0, 0);
    @(posedge clk); #1;

    // Reset asserted while a result is being held in OUT
    bus.out_ready = 1'b0;
    apply_stimulus(4'd2, ramp, shift_strip(ramp, 6));
    wait_result(lat);
    check_result("pre_rst_out", 2, lat, 6, 0, 2, 0);
    #2 rst_n = 1'b0;
    #1;
    check_idle("rst_out");
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;

    apply_stimulus(4'd0, fill_strip(8'h00), fill_strip(8'h00));
    wait_result(lat);
    check_result("final", 1, lat, 0, 0, 0, 0);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
